// File: rtl/pipelined_subtractor32_pkg.sv
// Shared arithmetic definitions for the pipelined subtractor datapath.
// Holds the slice width, the default slice count and the signed-overflow rule.
package pipelined_subtractor32_pkg;

    localparam int SLICE_W    = 8;
    localparam int SLICES_DEF = 4;

    // Two's-complement overflow of A - B: operand signs differ and result sign left A's sign.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb ^ b_msb) & (d_msb ^ a_msb);
    endfunction

endpackage

// File: rtl/pipelined_subtractor32_sub8_slice.sv
// Combinational 8-bit Kogge-Stone subtract slice: d = a - b - bin, bout = borrow out.
// Subtraction is done as a + ~b + ~bin with prefix levels at distances 1, 2 and 4.
module pipelined_subtractor32_sub8_slice
    import pipelined_subtractor32_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               bin,
    output logic [SLICE_W-1:0] d,
    output logic               bout
);

    logic [SLICE_W-1:0] w_y;
    logic               w_cin;
    logic [SLICE_W-1:0] w_g0, w_p0;
    logic [SLICE_W-1:0] w_g1, w_p1;
    logic [SLICE_W-1:0] w_g2, w_p2;
    logic [SLICE_W-1:0] w_g4, w_p4;
    logic [SLICE_W-1:0] w_c;

    assign w_y   = ~b;
    assign w_cin = ~bin;
    assign w_g0  = a & w_y;
    assign w_p0  = a ^ w_y;

    // After the distance-4 level, w_g4[i]/w_p4[i] span bits i..0.
    assign w_g1 = w_g0 | (w_p0 & {w_g0[SLICE_W-2:0], 1'b0});
    assign w_p1 = w_p0 & {w_p0[SLICE_W-2:0], 1'b1};
    assign w_g2 = w_g1 | (w_p1 & {w_g1[SLICE_W-3:0], 2'b00});
    assign w_p2 = w_p1 & {w_p1[SLICE_W-3:0], 2'b11};
    assign w_g4 = w_g2 | (w_p2 & {w_g2[SLICE_W-5:0], 4'b0000});
    assign w_p4 = w_p2 & {w_p2[SLICE_W-5:0], 4'b1111};

    assign w_c  = {w_g4[SLICE_W-2:0] | (w_p4[SLICE_W-2:0] & {(SLICE_W-1){w_cin}}), w_cin};
    assign d    = w_p0 ^ w_c;
    assign bout = ~(w_g4[SLICE_W-1] | (w_p4[SLICE_W-1] & w_cin));

endmodule

// File: rtl/pipelined_subtractor32.sv
// Pipelined W-bit subtractor, one 8-bit slice per stage, borrow registered between stages.
// Valid/ready on both sides with a combinational ready chain so bubbles compress.
module pipelined_subtractor32
    import pipelined_subtractor32_pkg::*;
#(
    parameter int SLICES = SLICES_DEF
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SLICE_W*SLICES-1:0] in_a,
    input  logic [SLICE_W*SLICES-1:0] in_b,
    input  logic                      in_borrow,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SLICE_W*SLICES-1:0] out_diff,
    output logic                      out_borrow,
    output logic                      out_ovf,
    output logic                      out_zero
);

    localparam int W = SLICE_W * SLICES;

    logic [W-1:0]       r_a [SLICES];
    logic [W-1:0]       r_b [SLICES];
    logic [W-1:0]       r_d [SLICES];
    logic [SLICES-1:0]  r_v;
    logic [SLICES-1:0]  r_bo;
    logic               r_ovf;
    logic               r_zero;

    logic [W-1:0]       w_ua [SLICES];
    logic [W-1:0]       w_ub [SLICES];
    logic [W-1:0]       w_ud [SLICES];
    logic [W-1:0]       w_nd [SLICES];
    logic [SLICES-1:0]  w_uv;
    logic [SLICES-1:0]  w_ubin;
    logic [SLICES-1:0]  w_sbo;
    logic [SLICES-1:0]  w_rdy;
    logic [SLICE_W-1:0] w_sa [SLICES];
    logic [SLICE_W-1:0] w_sb [SLICES];
    logic [SLICE_W-1:0] w_sd [SLICES];

    // Ready chain from the output back to stage 0; a stage is free if empty or its successor moves.
    always_comb begin
        logic w_down;
        w_rdy  = {SLICES{1'b0}};
        w_down = out_ready;
        for (int k = SLICES - 1; k >= 0; k--) begin
            w_rdy[k] = ~r_v[k] | w_down;
            w_down   = w_rdy[k];
        end
    end

    // Upstream view of each stage: the input port for stage 0, the previous stage otherwise.
    always_comb begin
        w_ua[0]   = in_a;
        w_ub[0]   = in_b;
        w_ud[0]   = {W{1'b0}};
        w_ubin[0] = in_borrow;
        w_uv[0]   = in_valid;
        for (int k = 1; k < SLICES; k++) begin
            w_ua[k]   = r_a[k-1];
            w_ub[k]   = r_b[k-1];
            w_ud[k]   = r_d[k-1];
            w_ubin[k] = r_bo[k-1];
            w_uv[k]   = r_v[k-1];
        end
        for (int k = 0; k < SLICES; k++) begin
            w_sa[k] = w_ua[k][k*SLICE_W +: SLICE_W];
            w_sb[k] = w_ub[k][k*SLICE_W +: SLICE_W];
        end
    end

    genvar g;
    for (g = 0; g < SLICES; g++) begin : g_slice
        pipelined_subtractor32_sub8_slice u_slice (
            .a    (w_sa[g]),
            .b    (w_sb[g]),
            .bin  (w_ubin[g]),
            .d    (w_sd[g]),
            .bout (w_sbo[g])
        );
    end

    // Merge each stage's freshly computed byte into the partial result it inherits.
    always_comb begin
        for (int k = 0; k < SLICES; k++) begin
            w_nd[k] = w_ud[k];
            w_nd[k][k*SLICE_W +: SLICE_W] = w_sd[k];
        end
    end

    // Stage registers: load on ready (bubbles included), hold otherwise; flags formed entering the last stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v    <= {SLICES{1'b0}};
            r_bo   <= {SLICES{1'b0}};
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
            for (int k = 0; k < SLICES; k++) begin
                r_a[k] <= {W{1'b0}};
                r_b[k] <= {W{1'b0}};
                r_d[k] <= {W{1'b0}};
            end
        end else begin
            for (int k = 0; k < SLICES; k++) begin
                if (w_rdy[k]) begin
                    r_v[k]  <= w_uv[k];
                    r_a[k]  <= w_ua[k];
                    r_b[k]  <= w_ub[k];
                    r_d[k]  <= w_nd[k];
                    r_bo[k] <= w_sbo[k];
                end
            end
            if (w_rdy[SLICES-1]) begin
                r_ovf  <= sub_ovf(w_ua[SLICES-1][W-1], w_ub[SLICES-1][W-1], w_nd[SLICES-1][W-1]);
                r_zero <= (w_nd[SLICES-1] == {W{1'b0}});
            end
        end
    end

    assign in_ready   = w_rdy[0];
    assign out_valid  = r_v[SLICES-1];
    assign out_diff   = r_d[SLICES-1];
    assign out_borrow = r_bo[SLICES-1];
    assign out_ovf    = r_ovf;
    assign out_zero   = r_zero;

endmodule

// File: tb/tb_pipelined_subtractor32.sv
// Scoreboard bench for pipelined_subtractor32: directed corner beats, backpressure,
// mid-flight reset and randomized traffic against a plain-arithmetic reference model.
module tb_pipelined_subtractor32;

    localparam int SLICES = 4;
    localparam int W      = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = 32'h0;
    logic [W-1:0] in_b = 32'h0;
    logic         in_borrow = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_diff;
    logic         out_borrow;
    logic         out_ovf;
    logic         out_zero;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        logic         z;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   n_out = 0;
    int   n_acc = 0;
    int   last_acc = 0;
    bit   hold_v = 1'b0;
    logic [W+2:0] held;
    bit   rand_on = 1'b0;

    pipelined_subtractor32 #(.SLICES(SLICES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_borrow  (in_borrow),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_diff   (out_diff),
        .out_borrow (out_borrow),
        .out_ovf    (out_ovf),
        .out_zero   (out_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Reference: exact integer arithmetic in 64 bits, then reduce.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        exp_t   m;
        longint ua, ub, lb, ud, sa, sb, sd;
        ua = a;
        ub = b;
        lb = bin;
        sa = $signed(a);
        sb = $signed(b);
        ud = ua - ub - lb;
        sd = sa - sb - lb;
        m.d  = ud[W-1:0];
        m.bo = (ud < 64'sd0);
        m.ov = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        m.z  = (m.d == 32'h0);
        return m;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one beat starting just after a rising edge; returns just after its accept edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        int t;
        in_a      = a;
        in_b      = b;
        in_borrow = bin;
        in_valid  = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk("send_timeout", {63'h0, in_ready}, 64'h1);
        end else begin
            sb_q.push_back(model(a, b, bin));
            n_acc++;
            last_acc = cyc + 1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain", sb_q.size(), 0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: pops on every output transfer and checks stall stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("stall_valid", {63'h0, out_valid}, 64'h1);
                chk("stall_stable", {29'h0, out_diff, out_borrow, out_ovf, out_zero}, {29'h0, held});
            end
            hold_v = out_valid && !out_ready;
            held   = {out_diff, out_borrow, out_ovf, out_zero};
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got diff %0h with empty scoreboard (t=%0t)", out_diff, $time);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("diff",   {32'h0, out_diff},   {32'h0, e.d});
                    chk("borrow", {63'h0, out_borrow}, {63'h0, e.bo});
                    chk("ovf",    {63'h0, out_ovf},    {63'h0, e.ov});
                    chk("zero",   {63'h0, out_zero},   {63'h0, e.z});
                    n_out++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int base;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid",  {63'h0, out_valid},  64'h0);
        chk("rst_out_diff",   {32'h0, out_diff},   64'h0);
        chk("rst_out_borrow", {63'h0, out_borrow}, 64'h0);
        chk("rst_out_ovf",    {63'h0, out_ovf},    64'h0);
        chk("rst_out_zero",   {63'h0, out_zero},   64'h0);
        chk("rst_in_ready",   {63'h0, in_ready},   64'h1);
        @(posedge clk);
        #1;

        // Basic subtract and latency: visible SLICES-1 edges after the accept edge
        send(32'h0000_0005, 32'h0000_0003, 1'b0);
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 20) begin
            t++;
            @(negedge clk);
        end
        chk("latency", cyc - last_acc, SLICES - 1);
        chk("basic_diff", {32'h0, out_diff}, 64'h2);
        drain();

        // Underflow, full borrow ripple, signed overflow, borrow-in to zero
        @(posedge clk);
        #1;
        send(32'h0000_0000, 32'h0000_0001, 1'b0);
        send(32'h0100_0000, 32'h0000_0001, 1'b0);
        send(32'h8000_0000, 32'h0000_0001, 1'b0);
        send(32'h1234_5678, 32'h1234_5677, 1'b1);
        drain();

        // Backpressure: 6 back-to-back beats, output stalled 5 cycles at first result
        base = n_out;
        fork
            begin
                for (int i = 0; i < 6; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)));
            end
            begin
                int acc0;
                int w;
                acc0 = n_acc;
                w = 0;
                while (!out_valid && w < 50) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
                out_ready = 1'b0;
                @(negedge clk);
                chk("bp_held_beats", n_acc - acc0, 4);
                chk("bp_in_ready", {63'h0, in_ready}, 64'h0);
                repeat (4) begin
                    @(negedge clk);
                    chk("bp_in_ready", {63'h0, in_ready}, 64'h0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", n_out - base, 6);

        // Reset with 3 beats in flight
        @(posedge clk);
        #1;
        send($urandom, $urandom, 1'b0);
        send($urandom, $urandom, 1'b0);
        send($urandom, $urandom, 1'b0);
        rst_n = 1'b0;
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("midrst_out_diff",  {32'h0, out_diff},  64'h0);
        chk("midrst_in_ready",  {63'h0, in_ready},  64'h1);
        repeat (12) @(negedge clk);
        @(posedge clk);
        #1;

        // Randomized traffic with random gaps and random output stalls
        rand_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(pick(), pick(), 1'($urandom_range(0, 1)));
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        drain();
        chk("final_queue_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
